tc_mra_arb: RTL

Two-port arbiter that shares the tile's single MRA request/response channel between the PF core and the SIMD core inside the tile controller. It accepts requests from both cores, grants them round-robin into one registered MRA request slot, and records the source of every issued request in an in-order ID FIFO. Each MRA response is routed back to the core that issued the matching request. It sits between the core-side request ports and the MRA link, under the tile control FSM.

---
 rtl/tc_pkg.sv | 20 ++
 rtl/tc_id_fifo.sv | 76 +++++++
 rtl/tc_mra_arb.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/tc_pkg.sv
// Shared types for the tile controller MRA arbiter.
//   tc_src_e     : request source ID (PF core = 0, SIMD core = 1)
//   tc_mra_req_t : MRA request payload at the default link widths
package tc_pkg;

    localparam int unsigned TC_ADDR_WIDTH = 64;
    localparam int unsigned TC_DATA_WIDTH = 512;

    typedef enum logic {
        TC_SRC_PF   = 1'b0,
        TC_SRC_SIMD = 1'b1
    } tc_src_e;

    typedef struct packed {
        logic [TC_ADDR_WIDTH-1:0] addr;
        logic                     we;
        logic [TC_DATA_WIDTH-1:0] wdata;
    } tc_mra_req_t;

endpackage

// File: rtl/tc_id_fifo.sv
// In-order FIFO of request source IDs.
//   clk, rst    : clock, synchronous active-high reset
//   push, din   : enqueue din (ignored when full unless popping in the same cycle)
//   pop, dout   : dequeue; dout is the current head
//   full, empty : status flags
//   count       : number of stored entries (0..DEPTH)
module tc_id_fifo
    import tc_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  tc_src_e                  din,
    output tc_src_e                  dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    tc_src_e             mem_q [DEPTH];
    tc_src_e             mem_d [DEPTH];
    logic [PtrW-1:0]     wptr_q, wptr_d;
    logic [PtrW-1:0]     rptr_q, rptr_d;
    logic [CntW-1:0]     count_q, count_d;
    logic                do_push, do_pop;

    assign full  = (count_q == CntW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rptr_q];

    // When full, a pop frees the head entry in the same cycle, so the push may
    // overwrite it: wptr equals rptr in that state and dout is read before the edge.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            mem_d[wptr_q] = din;
            wptr_d        = wptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + PtrW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q   <= '{default: TC_SRC_PF};
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/tc_mra_arb.sv
// Round-robin arbiter sharing the tile's MRA request/response channel between
// the PF core and the SIMD core.
//   clk, rst                 : clock, synchronous active-high reset
//   pf_req_* / simd_req_*    : core request ports (valid/ready, addr, we, wdata)
//   mra_req_*                : registered request slot toward the MRA
//   mra_rsp_valid/data       : in-order MRA responses, no backpressure
//   pf_rsp_* / simd_rsp_*    : routed response pulse and data (1 cycle after MRA)
//   busy                     : requests outstanding or slot occupied
//   err_unexp_rsp            : sticky, response arrived with nothing outstanding
module tc_mra_arb
    import tc_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned MAX_OUTST  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pf_req_valid,
    output logic                  pf_req_ready,
    input  logic [ADDR_WIDTH-1:0] pf_req_addr,
    input  logic                  pf_req_we,
    input  logic [DATA_WIDTH-1:0] pf_req_wdata,
    input  logic                  simd_req_valid,
    output logic                  simd_req_ready,
    input  logic [ADDR_WIDTH-1:0] simd_req_addr,
    input  logic                  simd_req_we,
    input  logic [DATA_WIDTH-1:0] simd_req_wdata,
    output logic                  mra_req_valid,
    input  logic                  mra_req_ready,
    output logic [ADDR_WIDTH-1:0] mra_req_addr,
    output logic                  mra_req_we,
    output logic [DATA_WIDTH-1:0] mra_req_wdata,
    input  logic                  mra_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mra_rsp_data,
    output logic                  pf_rsp_valid,
    output logic [DATA_WIDTH-1:0] pf_rsp_data,
    output logic                  simd_rsp_valid,
    output logic [DATA_WIDTH-1:0] simd_rsp_data,
    output logic                  busy,
    output logic                  err_unexp_rsp
);

    localparam int unsigned CntW = $clog2(MAX_OUTST) + 1;

    logic                  slot_valid_q, slot_valid_d;
    logic [ADDR_WIDTH-1:0] slot_addr_q, slot_addr_d;
    logic                  slot_we_q, slot_we_d;
    logic [DATA_WIDTH-1:0] slot_wdata_q, slot_wdata_d;
    tc_src_e               last_grant_q, last_grant_d;
    logic                  pf_rsp_valid_q, pf_rsp_valid_d;
    logic                  simd_rsp_valid_q, simd_rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  err_q, err_d;

    logic                  fifo_full, fifo_empty;
    logic [CntW-1:0]       fifo_count;
    tc_src_e               fifo_dout;
    tc_src_e               winner;
    logic                  slot_free, rsp_pop, cap_ok, can_grant, accept;

    tc_id_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_id_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (rsp_pop),
        .din   (winner),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        slot_free = !slot_valid_q || mra_req_ready;
        rsp_pop   = mra_rsp_valid && !fifo_empty;
        // A same-cycle pop makes room for the new entry even at full
        cap_ok    = !fifo_full || rsp_pop;
        can_grant = slot_free && cap_ok;

        if (pf_req_valid && simd_req_valid) begin
            winner = (last_grant_q == TC_SRC_SIMD) ? TC_SRC_PF : TC_SRC_SIMD;
        end else if (simd_req_valid) begin
            winner = TC_SRC_SIMD;
        end else begin
            winner = TC_SRC_PF;
        end

        pf_req_ready   = can_grant && pf_req_valid && (winner == TC_SRC_PF);
        simd_req_ready = can_grant && simd_req_valid && (winner == TC_SRC_SIMD);
        accept         = pf_req_ready || simd_req_ready;

        slot_valid_d = slot_valid_q;
        slot_addr_d  = slot_addr_q;
        slot_we_d    = slot_we_q;
        slot_wdata_d = slot_wdata_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            slot_valid_d = 1'b1;
            last_grant_d = winner;
            if (winner == TC_SRC_SIMD) begin
                slot_addr_d  = simd_req_addr;
                slot_we_d    = simd_req_we;
                slot_wdata_d = simd_req_wdata;
            end else begin
                slot_addr_d  = pf_req_addr;
                slot_we_d    = pf_req_we;
                slot_wdata_d = pf_req_wdata;
            end
        end else if (mra_req_ready) begin
            slot_valid_d = 1'b0;
        end

        pf_rsp_valid_d   = rsp_pop && (fifo_dout == TC_SRC_PF);
        simd_rsp_valid_d = rsp_pop && (fifo_dout == TC_SRC_SIMD);
        rsp_data_d       = rsp_pop ? mra_rsp_data : rsp_data_q;
        err_d            = err_q || (mra_rsp_valid && fifo_empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid_q     <= 1'b0;
            slot_addr_q      <= '0;
            slot_we_q        <= 1'b0;
            slot_wdata_q     <= '0;
            last_grant_q     <= TC_SRC_SIMD;
            pf_rsp_valid_q   <= 1'b0;
            simd_rsp_valid_q <= 1'b0;
            rsp_data_q       <= '0;
            err_q            <= 1'b0;
        end else begin
            slot_valid_q     <= slot_valid_d;
            slot_addr_q      <= slot_addr_d;
            slot_we_q        <= slot_we_d;
            slot_wdata_q     <= slot_wdata_d;
            last_grant_q     <= last_grant_d;
            pf_rsp_valid_q   <= pf_rsp_valid_d;
            simd_rsp_valid_q <= simd_rsp_valid_d;
            rsp_data_q       <= rsp_data_d;
            err_q            <= err_d;
        end
    end

    assign mra_req_valid  = slot_valid_q;
    assign mra_req_addr   = slot_addr_q;
    assign mra_req_we     = slot_we_q;
    assign mra_req_wdata  = slot_wdata_q;
    assign pf_rsp_valid   = pf_rsp_valid_q;
    assign simd_rsp_valid = simd_rsp_valid_q;
    assign pf_rsp_data    = rsp_data_q;
    assign simd_rsp_data  = rsp_data_q;
    // The slot is pushed into the FIFO on accept, so a non-empty count covers it too
    assign busy           = (fifo_count != '0) || slot_valid_q;
    assign err_unexp_rsp  = err_q;

endmodule
